mem_bus_arbiter: RTL

- Two-client to one-master arbiter for the memory bus. It sits directly upstream of the DRAM AXI bridge and drives that bridge's slave port.
- Arbitrates round-robin between client 0 and client 1, registers the granted request, and tags its ID with the client index.
- Routes read responses back to the owning client by the tag bit. Each client's outstanding reads are limited so neither client can starve the other.

---
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-client round-robin memory bus arbiter with tagged response routing
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 6,
    parameter int MAX_RD = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              c0_ms_valid,
    output logic              c0_ms_taken,
    input  logic              c0_ms_write,
    input  logic [ADDR_W-1:0] c0_ms_address,
    input  logic [DATA_W-1:0] c0_ms_data,
    input  logic [ID_W-2:0]   c0_ms_id,
    output logic              c0_sm_valid,
    input  logic              c0_sm_taken,
    output logic [DATA_W-1:0] c0_sm_data,
    output logic [ID_W-2:0]   c0_sm_id,

    input  logic              c1_ms_valid,
    output logic              c1_ms_taken,
    input  logic              c1_ms_write,
    input  logic [ADDR_W-1:0] c1_ms_address,
    input  logic [DATA_W-1:0] c1_ms_data,
    input  logic [ID_W-2:0]   c1_ms_id,
    output logic              c1_sm_valid,
    input  logic              c1_sm_taken,
    output logic [DATA_W-1:0] c1_sm_data,
    output logic [ID_W-2:0]   c1_sm_id,

    output logic              m_ms_valid,
    input  logic              m_ms_taken,
    output logic              m_ms_write,
    output logic [ADDR_W-1:0] m_ms_address,
    output logic [DATA_W-1:0] m_ms_data,
    output logic [ID_W-1:0]   m_ms_id,
    input  logic              m_sm_valid,
    output logic              m_sm_taken,
    input  logic [DATA_W-1:0] m_sm_data,
    input  logic [ID_W-1:0]   m_sm_id
);

    localparam int CW = $clog2(MAX_RD + 1);
    localparam logic [CW-1:0] MAX_RD_C = CW'(MAX_RD);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [CW-1:0]     rd_cnt [2];
    logic              ptr;
    logic              load_ok;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [1:0]        rd_inc;
    logic [1:0]        rd_dec;

    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic [ID_W-1:0]   buf_id;
    logic              buf_dst;
    logic              dst_taken;

    assign load_ok = !m_ms_valid || m_ms_taken;
    assign elig[0] = c0_ms_valid && (c0_ms_write || rd_cnt[0] < MAX_RD_C);
    assign elig[1] = c1_ms_valid && (c1_ms_write || rd_cnt[1] < MAX_RD_C);

    // ptr only matters when both clients compete; a lone eligible client always wins
    assign grant[0] = load_ok && elig[0] && (!elig[1] || !ptr);
    assign grant[1] = load_ok && elig[1] && (!elig[0] ||  ptr);

    assign c0_ms_taken = grant[0];
    assign c1_ms_taken = grant[1];

    assign rd_inc[0] = grant[0] && !c0_ms_write;
    assign rd_inc[1] = grant[1] && !c1_ms_write;
    assign rd_dec[0] = c0_sm_valid && c0_sm_taken;
    assign rd_dec[1] = c1_sm_valid && c1_sm_taken;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr          <= 1'b0;
            m_ms_valid   <= 1'b0;
            m_ms_write   <= 1'b0;
            m_ms_address <= '0;
            m_ms_data    <= '0;
            m_ms_id      <= '0;
        end else begin
            if (elig[0] && elig[1] && load_ok) begin
                ptr <= !ptr;
            end
            if (grant[0]) begin
                m_ms_valid   <= 1'b1;
                m_ms_write   <= c0_ms_write;
                m_ms_address <= c0_ms_address;
                m_ms_data    <= c0_ms_data;
                m_ms_id      <= {1'b0, c0_ms_id};
            end else if (grant[1]) begin
                m_ms_valid   <= 1'b1;
                m_ms_write   <= c1_ms_write;
                m_ms_address <= c1_ms_address;
                m_ms_data    <= c1_ms_data;
                m_ms_id      <= {1'b1, c1_ms_id};
            end else if (m_ms_taken) begin
                m_ms_valid   <= 1'b0;
            end
        end
    end

    // Decrement saturates so a stale response arriving after reset cannot wrap the count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt[0] <= '0;
            rd_cnt[1] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (rd_inc[n] && !rd_dec[n]) begin
                    rd_cnt[n] <= rd_cnt[n] + ONE_C;
                end else if (rd_dec[n] && !rd_inc[n] && rd_cnt[n] != '0) begin
                    rd_cnt[n] <= rd_cnt[n] - ONE_C;
                end
            end
        end
    end

    assign buf_dst    = buf_id[ID_W-1];
    assign dst_taken  = buf_dst ? c1_sm_taken : c0_sm_taken;
    assign m_sm_taken = !buf_valid || dst_taken;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_id    <= '0;
        end else if (m_sm_valid && m_sm_taken) begin
            buf_valid <= 1'b1;
            buf_data  <= m_sm_data;
            buf_id    <= m_sm_id;
        end else if (buf_valid && dst_taken) begin
            buf_valid <= 1'b0;
        end
    end

    assign c0_sm_valid = buf_valid && !buf_dst;
    assign c1_sm_valid = buf_valid &&  buf_dst;
    assign c0_sm_data  = buf_data;
    assign c1_sm_data  = buf_data;
    assign c0_sm_id    = buf_id[ID_W-2:0];
    assign c1_sm_id    = buf_id[ID_W-2:0];

endmodule
